// File: rtl/base_display_pkg.sv
// Shared base encodings and the Dec->Oct->Hex cycling rule for the display controller.
package base_display_pkg;

  typedef enum logic [1:0] {
    BASE_DEC = 2'b00,
    BASE_OCT = 2'b01,
    BASE_HEX = 2'b10
  } base_t;

  function automatic base_t next_base(input base_t b);
    case (b)
      BASE_DEC: return BASE_OCT;
      BASE_OCT: return BASE_HEX;
      default:  return BASE_DEC;
    endcase
  endfunction

endpackage

// File: rtl/base_display_controller_debouncer.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle press pulse
// on each debounced rising edge.
module button_debouncer
  import base_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any cycle agreeing with the current level restarts the stability count.
      if (sync_p1 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
          press <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/base_display_controller.sv
// Digit scanner and base-select sequencer for the RPN ALU display multiplexer.
// Optional feature: define BASE_AUTO_CYCLE_EN to add the AutoCiclo automatic base stepping.
module base_display_controller
  import base_display_pkg::*;
#(
`ifdef BASE_AUTO_CYCLE_EN
  parameter int AUTO_FRAMES     = 1000,
`endif
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_CYCLES     = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          BotaoBase,
`ifdef BASE_AUTO_CYCLE_EN
  input  logic                          AutoCiclo,
`endif
  output logic [1:0]                    Base,
  output logic [$clog2(NUM_DIGITS)-1:0] Digito,
  output logic [NUM_DIGITS-1:0]         Anodos,
  output logic                          Blank,
  output logic                          BaseMudou
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_CYCLES);

  logic          press;
  logic          btn_level;
  logic          auto_ev;
  logic [SW-1:0] scnt;
  logic [SW-1:0] scnt_nxt;
  logic [DW-1:0] dig_nxt;
  logic          scan_end;
  logic          wrap;
  base_t         base_cur;
  base_t         base_prox;
  base_t         prox_eff;
  base_t         base_nxt;
  logic          mudou_nxt;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (Clock),
    .rst_n (Reset_n),
    .btn   (BotaoBase),
    .level (btn_level),
    .press (press)
  );

  always_comb begin
    scan_end = (scnt == SW'(SCAN_CYCLES - 1));
    scnt_nxt = scan_end ? '0 : scnt + 1'b1;
    dig_nxt  = Digito;
    wrap     = 1'b0;
    if (scan_end) begin
      if (Digito == DW'(NUM_DIGITS - 1)) begin
        dig_nxt = '0;
        wrap    = 1'b1;
      end else begin
        dig_nxt = Digito + 1'b1;
      end
    end
  end

  // Scan stage: anodes follow the digit that will be active next cycle.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      scnt   <= '0;
      Digito <= '0;
      Anodos <= '1;
      Blank  <= 1'b1;
    end else begin
      scnt   <= scnt_nxt;
      Digito <= dig_nxt;
      if (scnt_nxt < SW'(BLANK_CYCLES)) begin
        Anodos <= '1;
        Blank  <= 1'b1;
      end else begin
        Anodos <= ~(NUM_DIGITS'(1) << dig_nxt);
        Blank  <= 1'b0;
      end
    end
  end

`ifdef BASE_AUTO_CYCLE_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);

  logic [FW-1:0] fcnt;

  assign auto_ev = AutoCiclo && wrap && (fcnt == FW'(AUTO_FRAMES - 1));

  always_ff @(posedge Clock) begin
    if (!Reset_n || !AutoCiclo) begin
      fcnt <= '0;
    end else if (wrap) begin
      fcnt <= auto_ev ? '0 : fcnt + 1'b1;
    end
  end
`else
  assign auto_ev = 1'b0;
`endif

  // A press and an automatic step landing on the same cycle advance the base twice.
  always_comb begin
    prox_eff = base_prox;
    if (press) begin
      prox_eff = next_base(prox_eff);
    end
    if (auto_ev) begin
      prox_eff = next_base(prox_eff);
    end
    base_nxt  = base_cur;
    mudou_nxt = 1'b0;
    if (wrap) begin
      base_nxt  = prox_eff;
      mudou_nxt = (prox_eff != base_cur);
    end
  end

  // Base stage: the pending base is only committed at the frame boundary.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      base_prox <= BASE_DEC;
      base_cur  <= BASE_DEC;
      BaseMudou <= 1'b0;
    end else begin
      base_prox <= prox_eff;
      base_cur  <= base_nxt;
      BaseMudou <= mudou_nxt;
    end
  end

  assign Base = base_cur;

endmodule

// File: tb/tb_base_display_controller.sv
// Directed bench for base_display_controller: scan timing table plus base-sequencing sequences.
module tb_base_display_controller;

  logic       clk;
  logic       rst_n;
  logic       bot;
  logic [1:0] base;
  logic [1:0] digito;
  logic [3:0] anodos;
  logic       blank;
  logic       mudou;
`ifdef BASE_AUTO_CYCLE_EN
  logic       auto_c;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  base_display_controller #(
`ifdef BASE_AUTO_CYCLE_EN
    .AUTO_FRAMES     (2),
`endif
    .NUM_DIGITS      (4),
    .SCAN_CYCLES     (8),
    .BLANK_CYCLES    (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .BotaoBase (bot),
`ifdef BASE_AUTO_CYCLE_EN
    .AutoCiclo (auto_c),
`endif
    .Base      (base),
    .Digito    (digito),
    .Anodos    (anodos),
    .Blank     (blank),
    .BaseMudou (mudou)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         cyc;
    logic [1:0] dig;
    logic [3:0] an;
    logic       blank;
  } scan_vec_t;

  scan_vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic press(input int hi, input int lo);
    bot = 1'b1;
    repeat (hi) tick();
    bot = 1'b0;
    repeat (lo) tick();
  endtask

  // Ticks up to the next frame wrap (cyc multiple of 32), then one cycle past it.
  task automatic run_to_wrap(input string nm, input logic [1:0] old_b, input logic [1:0] new_b);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cyc % 32 == 0) break;
      chk({nm, "_hold"}, {30'd0, base}, {30'd0, old_b});
      chk({nm, "_nopulse"}, {31'd0, mudou}, 32'd0);
    end
    chk({nm, "_base"}, {30'd0, base}, {30'd0, new_b});
    chk({nm, "_pulse"}, {31'd0, mudou}, {31'd0, (new_b != old_b)});
    tick();
    chk({nm, "_pulse_end"}, {31'd0, mudou}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{cyc: 1,  dig: 2'd0, an: 4'b1111, blank: 1'b1};
    vecs[1]  = '{cyc: 2,  dig: 2'd0, an: 4'b1110, blank: 1'b0};
    vecs[2]  = '{cyc: 7,  dig: 2'd0, an: 4'b1110, blank: 1'b0};
    vecs[3]  = '{cyc: 8,  dig: 2'd1, an: 4'b1111, blank: 1'b1};
    vecs[4]  = '{cyc: 9,  dig: 2'd1, an: 4'b1111, blank: 1'b1};
    vecs[5]  = '{cyc: 10, dig: 2'd1, an: 4'b1101, blank: 1'b0};
    vecs[6]  = '{cyc: 16, dig: 2'd2, an: 4'b1111, blank: 1'b1};
    vecs[7]  = '{cyc: 18, dig: 2'd2, an: 4'b1011, blank: 1'b0};
    vecs[8]  = '{cyc: 26, dig: 2'd3, an: 4'b0111, blank: 1'b0};
    vecs[9]  = '{cyc: 31, dig: 2'd3, an: 4'b0111, blank: 1'b0};
    vecs[10] = '{cyc: 32, dig: 2'd0, an: 4'b1111, blank: 1'b1};
    vecs[11] = '{cyc: 34, dig: 2'd0, an: 4'b1110, blank: 1'b0};

    rst_n = 1'b0;
    bot   = 1'b0;
`ifdef BASE_AUTO_CYCLE_EN
    auto_c = 1'b0;
`endif

    // Reset state and scan timing
    repeat (3) tick();
    chk("rst_base", {30'd0, base}, 32'd0);
    chk("rst_digito", {30'd0, digito}, 32'd0);
    chk("rst_anodos", {28'd0, anodos}, 32'hF);
    chk("rst_blank", {31'd0, blank}, 32'd1);
    chk("rst_mudou", {31'd0, mudou}, 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    for (int v = 0; v < 12; v++) begin
      while (cyc < vecs[v].cyc) tick();
      chk($sformatf("scan%0d_digito", v), {30'd0, digito}, {30'd0, vecs[v].dig});
      chk($sformatf("scan%0d_anodos", v), {28'd0, anodos}, {28'd0, vecs[v].an});
      chk($sformatf("scan%0d_blank", v), {31'd0, blank}, {31'd0, vecs[v].blank});
      chk($sformatf("scan%0d_base", v), {30'd0, base}, 32'd0);
    end

    // Bouncing input gives no event; a held press gives one
    for (int i = 0; i < 8; i++) begin
      bot = (i % 2 == 0);
      tick();
      chk("bounce_base", {30'd0, base}, 32'd0);
    end
    bot = 1'b1;
    repeat (10) tick();
    bot = 1'b0;
    run_to_wrap("single_press", 2'b00, 2'b01);

    // Three presses in one frame cancel out
    press(5, 6);
    press(5, 6);
    press(5, 0);
    run_to_wrap("three_press", 2'b01, 2'b01);

    // Press event landing exactly on the wrap cycle
    press(5, 6);
    run_to_wrap("to_hex", 2'b01, 2'b10);
    while (cyc < 153) tick();
    chk("pre_wrap_base", {30'd0, base}, 32'd2);
    press(5, 0);
    run_to_wrap("wrap_press", 2'b10, 2'b00);
    run_to_wrap("after_wrap_press", 2'b00, 2'b00);

    // Reset mid-frame discards the pending base
    press(5, 6);
    while (cyc < 210) tick();
    chk("pend_digito", {30'd0, digito}, 32'd2);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst2_base", {30'd0, base}, 32'd0);
    chk("rst2_digito", {30'd0, digito}, 32'd0);
    chk("rst2_anodos", {28'd0, anodos}, 32'hF);
    chk("rst2_blank", {31'd0, blank}, 32'd1);
    rst_n = 1'b1;
    cyc   = 0;
    run_to_wrap("discard1", 2'b00, 2'b00);
    run_to_wrap("discard2", 2'b00, 2'b00);

`ifdef BASE_AUTO_CYCLE_EN
    // Automatic stepping every second wrap, combined with a manual press
    auto_c = 1'b1;
    run_to_wrap("auto_a", 2'b00, 2'b00);
    run_to_wrap("auto_b", 2'b00, 2'b01);
    run_to_wrap("auto_c", 2'b01, 2'b01);
    run_to_wrap("auto_d", 2'b01, 2'b10);
    run_to_wrap("auto_e", 2'b10, 2'b10);
    while (cyc < 249) tick();
    press(5, 0);
    run_to_wrap("auto_plus_press", 2'b10, 2'b01);
    auto_c = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
